// File: rtl/pipe_stage_reg.sv
// Pipeline stage boundary register with valid/ready handshake, 2-entry skid buffer,
// flush/hold controls and saturating stall/flush event counters.
module pipe_stage_reg #(
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned CTRL_W          = 8,
   parameter int unsigned CNT_W           = 16,
   parameter bit          FLUSH_ZERO_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              hold,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_data;
   logic              s_valid;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] s_data;

   logic accept;
   logic fire;

   always_comb begin
      in_ready  = !s_valid && !hold;
      out_valid = m_valid;
      out_ctrl  = m_valid ? m_ctrl : '0;
      out_data  = m_data;
      occ       = {1'b0, m_valid} + {1'b0, s_valid};
      accept    = in_valid && in_ready;
      fire      = m_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         m_valid   <= 1'b0;
         m_ctrl    <= '0;
         m_data    <= '0;
         s_valid   <= 1'b0;
         s_ctrl    <= '0;
         s_data    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         // Counters run independently of the entry update, including in flush cycles.
         if (m_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);

         if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= '0;
            s_ctrl  <= '0;
            if (FLUSH_ZERO_DATA) begin
               m_data <= '0;
               s_data <= '0;
            end
         end else if (fire) begin
            if (s_valid) begin
               m_ctrl  <= s_ctrl;
               m_data  <= s_data;
               s_valid <= 1'b0;
            end else if (accept) begin
               m_ctrl <= in_ctrl;
               m_data <= in_data;
            end else begin
               m_valid <= 1'b0;
            end
         end else if (accept) begin
            if (!m_valid) begin
               m_valid <= 1'b1;
               m_ctrl  <= in_ctrl;
               m_data  <= in_data;
            end else begin
               s_valid <= 1'b1;
               s_ctrl  <= in_ctrl;
               s_data  <= in_data;
            end
         end
      end
   end

endmodule
